spi_xfer_ctrl: RTL and testbench
================================

# spi_xfer_ctrl

Byte-stream transfer controller that sits directly upstream of `spi_core` and drives its `cs`/`rd`/`wr`/`din` host port. It buffers outgoing bytes in a TX FIFO, launches one `spi_core` transfer per byte, waits for `done`, reads back the received byte, and delivers it through an RX FIFO with valid/ready handshakes. A watchdog flags a core that never reports `done`.

## Interface

Parameters:
- `DWIDTH`, 8: byte width; must match `spi_core` `DWIDTH`.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT_DONE before abort; ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, shared with `spi_core`.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in DWIDTH: byte to send.
- `tx_valid` in 1: `tx_data` offered.
- `tx_ready` out 1: TX FIFO not full.
- `rx_data` out DWIDTH: received byte (RX FIFO head).
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: consumer takes `rx_data`.
- `core_cs` out 1: to `spi_core.cs`.
- `core_wr` out 1: to `spi_core.wr`.
- `core_rd` out 1: to `spi_core.rd`.
- `core_din` out DWIDTH: to `spi_core.din`.
- `core_dout` in DWIDTH: from `spi_core.dout`.
- `core_done` in 1: from `spi_core.done`.
- `busy` out 1: FSM not in IDLE.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation

- Handshakes: TX push when `tx_valid & tx_ready`; RX pop when `rx_valid & rx_ready`. Push and pop in the same cycle on a full FIFO are legal only if a pop also occurs; push on full is ignored (`tx_ready` low prevents it).
- FSM states: IDLE, START, WAIT_DONE, READ, CAPTURE.
  - IDLE → START when TX FIFO non-empty and RX FIFO has ≥1 free entry counting no in-flight byte; otherwise stay.
  - START (1 cycle): `core_cs=1`, `core_wr=1`, `core_rd=0`, `core_din`=TX head; TX pop; timer cleared → WAIT_DONE.
  - WAIT_DONE: `core_cs=1`, wr/rd 0; `core_done`=1 → READ; timer reaching TIMEOUT → set `err`, drop the byte, → IDLE.
  - READ (1 cycle): `core_cs=1`, `core_rd=1`, `core_wr=0` → CAPTURE.
  - CAPTURE (1 cycle): `core_cs=0`; push `core_dout` into RX FIFO → IDLE.
- `core_rd` and `core_wr` are never high together in any cycle.
- `core_din` holds its last value outside START; `core_cs` is low in IDLE and CAPTURE.
- `err` set by timeout, cleared by `err_clr`; simultaneous set and clear: set wins. `err` does not stall the FSM.
- Timer width is clog2(TIMEOUT+1); no wrap-around, because it saturates at TIMEOUT.

## Timing

- Reset values: `core_cs/wr/rd`=0, `core_din`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `busy`=0, `err`=0; FIFOs empty; FSM IDLE; timer 0.
- A reset mid-transfer aborts immediately; the in-flight byte and all FIFO contents are discarded.
- Byte accepted on TX at edge ending cycle t, with an idle FSM and empty TX FIFO → `core_wr` high in cycle t+2.
- `core_done` first high in cycle d → `core_rd` high in d+1, RX push at end of d+2, `rx_valid` high in d+3.
- Back-to-back bytes: next `core_wr` no earlier than 2 cycles after CAPTURE.
- FIFO count and status flags update on the same edge as push/pop; no bypass path.

## Structure

- Shared package `spi_pkg`: FSM state encoding (3-bit), default DWIDTH, clog2 helper.
- Sub-module `spi_fifo` (synchronous FIFO, params DWIDTH/DEPTH, ports `clk`, `rst`, push, pop, din, dout, full, empty, count), instantiated twice for TX and RX.
- FSM, timer and err logic live in `spi_xfer_ctrl`. Verify against `spi_core` plus an `spi_shreg` secondary model.

## Test plan

- Single byte: push 0xA5 with secondary preloaded 0x3C → `core_wr` pulse with `core_din`=0xA5; rx_data=0x3C three cycles after `done`; the secondary then holds 0xA5.
- Burst: push 0x01..0x04 with rx_ready=1 → four transfers in order; RX returns the previous secondary contents in order; `rd & wr` never both high.
- RX backpressure: rx_ready=0, push 6 bytes (DEPTH=4) → exactly 4 transfers; `tx_ready` falls when TX is full; after asserting rx_ready, the remaining 2 complete.
- Timeout: tie `core_done`=0, TIMEOUT=15, push 0x55 → `err`=1 exactly 15 cycles after START; FSM back to IDLE; nothing pushed to RX; `err_clr` → `err`=0.
- Reset in WAIT_DONE: assert `rst` for 1 cycle → all outputs at their reset values next cycle; a subsequent push of 0x7E completes normally.
- Simultaneous: `err_clr` on the timeout cycle → `err`=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller.
// FSM encoding, default byte width and a clog2 helper.
package spi_pkg;

  localparam int DWIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_CAPT  = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO used for the TX and RX byte queues.
// Head reads as zero while empty; no bypass path.
module spi_fifo
  import spi_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DWIDTH-1:0]      din,
  output logic [DWIDTH-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rp];

  // Pointers and occupancy move on the push/pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; empty gates the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte-stream controller in front of spi_core.
// One core transfer per TX byte; result goes to RX.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              core_cs,
  output logic              core_wr,
  output logic              core_rd,
  output logic [DWIDTH-1:0] core_din,
  input  logic [DWIDTH-1:0] core_dout,
  input  logic              core_done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int TW = clog2(TIMEOUT + 1);
  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

  state_t            state;
  logic [TW-1:0]     timer;
  logic [DWIDTH-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     rx_count;
  logic              tx_pop;
  logic              rx_push;
  logic              unused_ok;

  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign tx_pop    = (state == S_START);
  assign rx_push   = (state == S_CAPT);
  assign busy      = (state != S_IDLE);
  assign unused_ok = ^{tx_count, rx_count};

  spi_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (tx_pop),
    .din   (tx_data),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  spi_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_ready),
    .din   (core_dout),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Transfer sequencer with registered core strobes,
  // watchdog timer and sticky error (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      core_cs  <= 1'b0;
      core_wr  <= 1'b0;
      core_rd  <= 1'b0;
      core_din <= '0;
      timer    <= '0;
      err      <= 1'b0;
    end else begin
      if (err_clr) err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!tx_empty && !rx_full) begin
            state    <= S_START;
            core_cs  <= 1'b1;
            core_wr  <= 1'b1;
            core_din <= tx_head;
          end
        end
        S_START: begin
          state   <= S_WAIT;
          core_wr <= 1'b0;
          timer   <= '0;
        end
        S_WAIT: begin
          if (core_done) begin
            state   <= S_READ;
            core_rd <= 1'b1;
          end else if (timer == TLAST) begin
            state   <= S_IDLE;
            core_cs <= 1'b0;
            err     <= 1'b1;
          end else if (timer != TMAX) begin
            timer <= timer + 1'b1;
          end
        end
        S_READ: begin
          state   <= S_CAPT;
          core_rd <= 1'b0;
          core_cs <= 1'b0;
        end
        S_CAPT: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          core_cs <= 1'b0;
          core_wr <= 1'b0;
          core_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl with a behavioural spi_core
// and secondary shift register standing in for the bus.
module tb_spi_xfer_ctrl;

  localparam int DW  = 8;
  localparam int DP  = 4;
  localparam int TO  = 15;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          core_cs;
  logic          core_wr;
  logic          core_rd;
  logic [DW-1:0] core_din;
  logic [DW-1:0] core_dout = '0;
  logic          core_done = 1'b0;
  logic          busy;
  logic          err;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .DWIDTH  (DW),
    .DEPTH   (DP),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .core_cs   (core_cs),
    .core_wr   (core_wr),
    .core_rd   (core_rd),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_done (core_done),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core + secondary: a write swaps din into the secondary,
  // dout shows the old contents, done LAT+1 cycles later.
  logic [DW-1:0] sec = '0;
  logic [3:0]    cnt = '0;
  logic          hang = 1'b0;
  logic          preload = 1'b0;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (preload) begin
      sec <= 8'h3C;
      cnt <= '0;
    end else if (core_cs && core_wr) begin
      core_dout <= sec;
      sec       <= core_din;
      cnt       <= 4'(LAT);
    end else if (cnt != 0) begin
      cnt <= cnt - 1'b1;
      if (cnt == 1 && !hang) core_done <= 1'b1;
    end
  end

  int            nwr = 0;
  int            rdwr_bad = 0;
  logic [DW-1:0] wr_log [$];
  int            wr_cyc [$];
  logic [DW-1:0] rx_log [$];

  always @(negedge clk) begin
    #1;
    if (core_rd && core_wr) rdwr_bad++;
    if (core_wr) begin
      nwr++;
      wr_log.push_back(core_din);
      wr_cyc.push_back(cyc);
    end
    if (rx_valid && rx_ready) rx_log.push_back(rx_data);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    rx_log.delete();
  endtask

  task automatic push(input logic [DW-1:0] b,
                      output int c, output bit waited);
    int k;
    k = 0;
    waited = 1'b0;
    while (!tx_ready && k < 200) begin
      waited = 1'b1;
      @(negedge clk);
      k++;
    end
    if (k == 200) check("push_ready", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    c = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_wr(output int c);
    int k;
    k = 0;
    while (!core_wr && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k == 40) check("wr_timeout", 32'(core_wr), 1);
    c = cyc;
  endtask

  task automatic wait_done(output int c);
    int k;
    k = 0;
    while (!core_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k == 40) check("done_timeout", 32'(core_done), 1);
    c = cyc;
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_log.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k == 300) check("rx_count", rx_log.size(), n);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } vec_t;

  vec_t tab [4];
  logic [DW-1:0] exp_b [6];

  initial begin
    int t, w, d, s, n0;
    bit wt, seen_full;

    tab[0] = '{8'hA5, 8'h3C};
    tab[1] = '{8'h5A, 8'hA5};
    tab[2] = '{8'h00, 8'h5A};
    tab[3] = '{8'hFF, 8'h00};

    // reset state
    preload = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    check("rst_cs", 32'(core_cs), 0);
    check("rst_wr", 32'(core_wr), 0);
    check("rst_rd", 32'(core_rd), 0);
    check("rst_din", 32'(core_din), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);

    // single-byte transfers, one per table row
    for (int i = 0; i < 4; i++) begin
      push(tab[i].tx, t, wt);
      wait_wr(w);
      check("wr_latency", w, t + 2);
      check("wr_din", 32'(core_din), 32'(tab[i].tx));
      check("wr_cs", 32'(core_cs), 1);
      check("wr_busy", 32'(busy), 1);
      wait_done(d);
      @(negedge clk);
      check("rd_at_d1", 32'(core_rd), 1);
      check("wr_at_d1", 32'(core_wr), 0);
      @(negedge clk);
      check("capt_cs", 32'(core_cs), 0);
      check("rx_not_yet", 32'(rx_valid), 0);
      @(negedge clk);
      check("rx_valid_d3", 32'(rx_valid), 1);
      check("rx_data", 32'(rx_data), 32'(tab[i].rx));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("rx_popped", 32'(rx_valid), 0);
    end

    // burst with a free-running consumer
    clear_logs();
    n0 = nwr;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(i + 1), t, wt);
    wait_rx(4);
    rx_ready = 1'b0;
    check("burst_xfers", nwr - n0, 4);
    exp_b[0] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      check("burst_tx_order", 32'(wr_log[i]), i + 1);
      if (i > 0) exp_b[i] = 8'(i);
      check("burst_rx_order", 32'(rx_log[i]), 32'(exp_b[i]));
    end
    // START, 4 wait, READ, CAPTURE, IDLE, START
    check("burst_gap", wr_cyc[1] - wr_cyc[0], 8);

    // RX backpressure: only DEPTH transfers fit
    clear_logs();
    n0 = nwr;
    seen_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), t, wt);
      if (wt) seen_full = 1'b1;
    end
    repeat (60) @(negedge clk);
    check("bp_seen_full", 32'(seen_full), 1);
    check("bp_xfers", nwr - n0, 4);
    check("bp_busy", 32'(busy), 0);
    check("bp_rx_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    wait_rx(6);
    rx_ready = 1'b0;
    check("bp_xfers_all", nwr - n0, 6);
    exp_b[0] = 8'h04;
    for (int i = 1; i < 6; i++) exp_b[i] = 8'h10 + 8'(i - 1);
    for (int i = 0; i < 6; i++) begin
      check("bp_tx_order", 32'(wr_log[i]), 32'(8'h10 + 8'(i)));
      check("bp_rx_order", 32'(rx_log[i]), 32'(exp_b[i]));
    end

    // watchdog: WAIT_DONE lasts TO cycles, then abort
    clear_logs();
    hang = 1'b1;
    n0 = nwr;
    push(8'h55, t, wt);
    wait_wr(s);
    repeat (TO) @(negedge clk);
    check("to_err_early", 32'(err), 0);
    check("to_busy_early", 32'(busy), 1);
    @(negedge clk);
    check("to_err_set", 32'(err), 1);
    check("to_idle", 32'(busy), 0);
    check("to_cs_low", 32'(core_cs), 0);
    repeat (3) @(negedge clk);
    check("to_err_sticky", 32'(err), 1);
    check("to_no_rx", 32'(rx_valid), 0);
    check("to_one_xfer", nwr - n0, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", 32'(err), 0);

    // clear on the timeout edge loses to set
    push(8'h66, t, wt);
    wait_wr(s);
    repeat (TO) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("set_beats_clr", 32'(err), 1);

    // reset during WAIT_DONE with a byte queued behind
    push(8'h77, t, wt);
    push(8'h78, t, wt);
    wait_wr(s);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cs", 32'(core_cs), 0);
    check("mid_rst_wr", 32'(core_wr), 0);
    check("mid_rst_rd", 32'(core_rd), 0);
    check("mid_rst_din", 32'(core_din), 0);
    check("mid_rst_tx_ready", 32'(tx_ready), 1);
    check("mid_rst_rx_valid", 32'(rx_valid), 0);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_err", 32'(err), 0);
    n0 = nwr;
    repeat (20) @(negedge clk);
    check("rst_tx_flushed", nwr - n0, 0);
    hang = 1'b0;
    clear_logs();
    push(8'h7E, t, wt);
    wait_wr(w);
    check("post_rst_latency", w, t + 2);
    check("post_rst_din", 32'(core_din), 32'h7E);
    wait_done(d);
    repeat (3) @(negedge clk);
    check("post_rst_rx_valid", 32'(rx_valid), 1);
    check("post_rst_rx_data", 32'(rx_data), 32'h77);

    check("rd_wr_overlap", rdwr_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
